// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, drives fetch_addr into a combinational instruction memory,
// captures {PC, instruction} into a DEPTH-entry prefetch queue and presents its head to decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module fetch_sequencer #(
  parameter int                ADDR_W   = 72,
  parameter int                INSTR_W  = 72,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic [ADDR_W-1:0]          fetch_addr,
  input  logic [INSTR_W-1:0]         fetch_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH):0]     fill_level
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                perf_fetched,
  output logic [31:0]                perf_stall
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

  logic [ADDR_W-1:0]  r_pc;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [INSTR_W-1:0] r_q_instr [DEPTH];
  logic [ADDR_W-1:0]  r_q_pc    [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // Redirect outranks everything: it blocks both the push and the pop of that cycle,
  // so a head offered during a redirect is never counted as consumed.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready && !redirect_valid;
  assign w_push  = fetch_en && !redirect_valid && (!w_full || w_pop);

  assign fetch_addr = r_pc;
  assign out_valid  = !w_empty;
  assign out_instr  = r_q_instr[r_rd_ptr];
  assign out_pc     = r_q_pc[r_rd_ptr];
  assign fill_level = r_count;

  // Program counter: load redirect target, advance on each push, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= redirect_addr;
    end else if (w_push) begin
      r_pc <= r_pc + PC_ONE;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue by resetting both pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // Queue storage: cleared on reset so the head reads back as zero until the first push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_q_instr[r_wr_ptr] <= fetch_instr;
      r_q_pc[r_wr_ptr]    <= r_pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  // Count fetched instructions, and cycles lost to a full queue with no drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (fetch_en && w_full && !w_pop && !redirect_valid) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule
